// File: rtl/camera_cfg_pkg.sv
// Shared types and constants for the OV7670 configuration sequencer.
package camera_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_WAIT_DONE,
        ST_DELAY,
        ST_DONE
    } cfg_state_t;

    // Markers match on all 16 bits, so a word like 16'hFF05 is still a normal write.
    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] value;
    } cfg_word_t;

    function automatic cfg_word_t to_cfg_word(input logic [15:0] raw);
        return cfg_word_t'(raw);
    endfunction

endpackage

// File: rtl/camera_config_sequencer_if.sv
// Write-request channel between the config sequencer and the SCCB master.
interface camera_config_sequencer_if;

    logic       o_sccb_valid;
    logic       i_sccb_ready;
    logic [7:0] o_sccb_reg;
    logic [7:0] o_sccb_data;
    logic       i_sccb_done;

    modport master (
        output o_sccb_valid,
        output o_sccb_reg,
        output o_sccb_data,
        input  i_sccb_ready,
        input  i_sccb_done
    );

    modport slave (
        input  o_sccb_valid,
        input  o_sccb_reg,
        input  o_sccb_data,
        output i_sccb_ready,
        output i_sccb_done
    );

endinterface

// File: rtl/cfg_delay_timer.sv
// One-shot down counter: after a load it raises o_expired on its DELAY_CYCLES-th cycle.
module cfg_delay_timer #(
    parameter int DELAY_CYCLES = 1_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    output logic o_expired
);

    localparam int            CW         = $clog2(DELAY_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VALUE = CW'(DELAY_CYCLES - 1);

    if (DELAY_CYCLES < 1) begin : g_bad_delay
        $error("cfg_delay_timer: DELAY_CYCLES must be at least 1");
    end

    logic [CW-1:0] count_reg;
    logic          active_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_reg  <= '0;
            active_reg <= 1'b0;
        end else if (i_load) begin
            count_reg  <= LOAD_VALUE;
            active_reg <= 1'b1;
        end else if (active_reg) begin
            // Expiry is a single-cycle event; the timer idles until reloaded.
            if (count_reg == '0) begin
                active_reg <= 1'b0;
            end else begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    assign o_expired = active_reg && (count_reg == '0);

endmodule

// File: rtl/camera_config_sequencer.sv
// Walks the OV7670 config ROM from address 0 and issues one SCCB write per word,
// honouring the delay (16'hFFF0) and end (16'hFFFF) markers.
module camera_config_sequencer
    import camera_cfg_pkg::*;
#(
    parameter int DELAY_CYCLES = 1_000_000,
    parameter int ROM_LATENCY  = 2,
    parameter int MAX_ADDR     = 255
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    output logic [7:0]                       o_rom_addr,
    input  logic [15:0]                      i_rom_data,
    camera_config_sequencer_if.master        sccb,
    output logic                             o_busy,
    output logic                             o_done
);

    localparam int            FW         = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
    localparam logic [FW-1:0] FETCH_LAST = FW'(ROM_LATENCY - 1);
    localparam logic [7:0]    LAST_ADDR  = 8'(MAX_ADDR);

    if (ROM_LATENCY < 1) begin : g_bad_latency
        $error("camera_config_sequencer: ROM_LATENCY must be at least 1");
    end

    cfg_state_t    state_reg, state_next;
    logic [7:0]    addr_reg, addr_next;
    logic [FW-1:0] fetch_cnt_reg, fetch_cnt_next;
    cfg_word_t     word_reg, word_next;
    logic          valid_reg, valid_next;
    logic [7:0]    reg_addr_reg, reg_addr_next;
    logic [7:0]    value_reg, value_next;
    logic          busy_reg, busy_next;
    logic          done_reg, done_next;

    logic          timer_load;
    logic          timer_expired;
    logic          fetch_last;
    logic          accept;
    logic          advance;
    logic          at_last_addr;
    logic [15:0]   word_raw;

    cfg_delay_timer #(
        .DELAY_CYCLES (DELAY_CYCLES)
    ) u_delay_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (timer_load),
        .o_expired (timer_expired)
    );

    assign word_raw     = word_reg;
    assign fetch_last   = (fetch_cnt_reg == FETCH_LAST);
    assign accept       = valid_reg && sccb.i_sccb_ready;
    assign at_last_addr = (addr_reg == LAST_ADDR);
    // Done pulses outside WAIT_DONE fall through here and are dropped.
    assign advance      = ((state_reg == ST_WAIT_DONE) && sccb.i_sccb_done) ||
                          ((state_reg == ST_DELAY) && timer_expired);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            fetch_cnt_reg <= '0;
            word_reg      <= '0;
            valid_reg     <= 1'b0;
            reg_addr_reg  <= '0;
            value_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            fetch_cnt_reg <= fetch_cnt_next;
            word_reg      <= word_next;
            valid_reg     <= valid_next;
            reg_addr_reg  <= reg_addr_next;
            value_reg     <= value_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (i_start) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (fetch_last) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (word_raw == CFG_END)        state_next = ST_DONE;
                else if (word_raw == CFG_DELAY) state_next = ST_DELAY;
                else                            state_next = ST_SEND;
            end
            ST_SEND: begin
                if (accept) state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE, ST_DELAY: begin
                if (advance) state_next = at_last_addr ? ST_DONE : ST_FETCH;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_next      = addr_reg;
        fetch_cnt_next = fetch_cnt_reg;
        word_next      = word_reg;
        valid_next     = valid_reg;
        reg_addr_next  = reg_addr_reg;
        value_next     = value_reg;
        busy_next      = busy_reg;
        done_next      = done_reg;
        timer_load     = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    addr_next      = '0;
                    fetch_cnt_next = '0;
                    busy_next      = 1'b1;
                    done_next      = 1'b0;
                end
            end
            ST_FETCH: begin
                // The word is latched on the edge the ROM output becomes valid.
                if (fetch_last) begin
                    word_next = to_cfg_word(i_rom_data);
                end else begin
                    fetch_cnt_next = fetch_cnt_reg + FW'(1);
                end
            end
            ST_DECODE: begin
                if (word_raw == CFG_END) begin
                    busy_next = 1'b0;
                    done_next = 1'b1;
                end else if (word_raw == CFG_DELAY) begin
                    timer_load = 1'b1;
                end else begin
                    reg_addr_next = word_reg.reg_addr;
                    value_next    = word_reg.value;
                    valid_next    = 1'b1;
                end
            end
            ST_SEND: begin
                if (accept) valid_next = 1'b0;
            end
            ST_WAIT_DONE, ST_DELAY: begin
                // The last address ends the run in place; the address never wraps.
                if (advance) begin
                    if (at_last_addr) begin
                        busy_next = 1'b0;
                        done_next = 1'b1;
                    end else begin
                        addr_next      = addr_reg + 8'd1;
                        fetch_cnt_next = '0;
                    end
                end
            end
            default: ;
        endcase
    end

    assign o_rom_addr       = addr_reg;
    assign sccb.o_sccb_valid = valid_reg;
    assign sccb.o_sccb_reg  = reg_addr_reg;
    assign sccb.o_sccb_data = value_reg;
    assign o_busy           = busy_reg;
    assign o_done           = done_reg;

endmodule

// File: tb/tb_camera_config_sequencer.sv
// Directed bench: ROM and SCCB master models, expected writes checked by a scoreboard monitor.
module tb_camera_config_sequencer;

    localparam int DELAY_CYCLES = 16;
    localparam int ROM_LATENCY  = 2;
    localparam int MAX_ADDR     = 255;
    localparam int DONE_DELAY   = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        busy;
    logic        done;

    camera_config_sequencer_if sccb();

    camera_config_sequencer #(
        .DELAY_CYCLES (DELAY_CYCLES),
        .ROM_LATENCY  (ROM_LATENCY),
        .MAX_ADDR     (MAX_ADDR)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data),
        .sccb       (sccb),
        .o_busy     (busy),
        .o_done     (done)
    );

    always #5 clk = ~clk;

    // ROM model: the word for a new address is on i_rom_data at the
    // ROM_LATENCY-th rising edge after the address changes.
    logic [15:0] rom [256];
    logic [15:0] rom_q;
    always @(posedge clk) rom_q <= rom[rom_addr];
    assign rom_data = rom_q;

    int          checks = 0;
    int          errors = 0;
    int          accept_count = 0;
    int          stall_cnt = 0;
    int          done_cnt = 0;
    bit          hold_ready_low = 1'b0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // SCCB master model: random 0-5 cycle ready stall, done pulse 20 cycles after accept.
    initial begin : sccb_model
        sccb.i_sccb_ready = 1'b0;
        sccb.i_sccb_done  = 1'b0;
        stall_cnt = int'($urandom_range(5, 0));
        forever begin
            @(negedge clk);
            sccb.i_sccb_done = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) sccb.i_sccb_done = 1'b1;
            end
            if (sccb.i_sccb_ready) begin
                sccb.i_sccb_ready = 1'b0;
                done_cnt  = DONE_DELAY;
                stall_cnt = int'($urandom_range(5, 0));
            end else if (sccb.o_sccb_valid === 1'b1 && !hold_ready_low) begin
                if (stall_cnt == 0) sccb.i_sccb_ready = 1'b1;
                else stall_cnt--;
            end
        end
    end

    // Scoreboard monitor: each accepted write is compared with the oldest expected one.
    initial begin : monitor
        logic [15:0] exp_word;
        forever begin
            @(negedge clk);
            #1;
            if (sccb.o_sccb_valid === 1'b1 && sccb.i_sccb_ready === 1'b1) begin
                accept_count++;
                $display("write %0d: reg=%02h data=%02h", accept_count, sccb.o_sccb_reg, sccb.o_sccb_data);
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'({sccb.o_sccb_reg, sccb.o_sccb_data}), 32'hFFFF_FFFF);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("write_word", 32'({sccb.o_sccb_reg, sccb.o_sccb_data}), 32'(exp_word));
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_accepts(input string name, input int target, input int max_cycles);
        int k = 0;
        while (accept_count < target && k < max_cycles) begin
            step(1);
            k++;
        end
        check(name, 32'(accept_count >= target), 32'd1);
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int k = 0;
        while (done !== 1'b1 && k < max_cycles) begin
            step(1);
            k++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    task automatic wait_addr(input string name, input logic [7:0] addr, input int max_cycles);
        int k = 0;
        while (rom_addr !== addr && k < max_cycles) begin
            step(1);
            k++;
        end
        check(name, 32'(rom_addr), 32'(addr));
    endtask

    task automatic load_basic_rom();
        foreach (rom[i]) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        rom[1] = 16'hFFF0;
        rom[2] = 16'h1214;
        rom[3] = 16'hFFFF;
    endtask

    initial begin : stimulus
        int base;
        int k;
        int stable;

        rst   = 1'b1;
        start = 1'b0;
        foreach (rom[i]) rom[i] = 16'hFFFF;
        step(3);
        check("rst_addr",  32'(rom_addr), 32'd0);
        check("rst_valid", 32'(sccb.o_sccb_valid), 32'd0);
        check("rst_reg",   32'(sccb.o_sccb_reg), 32'd0);
        check("rst_data",  32'(sccb.o_sccb_data), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        rst = 1'b0;
        step(2);

        // 1: basic sequence with a delay marker
        load_basic_rom();
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1214);
        base = accept_count;
        pulse_start();
        check("s1_busy", 32'(busy), 32'd1);
        check("s1_done_low", 32'(done), 32'd0);
        wait_accepts("s1_first_write", base + 1, 200);
        k = 0;
        while (sccb.i_sccb_done !== 1'b1 && k < 200) begin
            step(1);
            k++;
        end
        check("s1_done_pulse", 32'(sccb.i_sccb_done), 32'd1);
        k = 0;
        while (rom_addr !== 8'd2 && k < 200) begin
            step(1);
            k++;
        end
        // done edge, ROM_LATENCY fetch cycles, 1 decode, DELAY_CYCLES, then the advance edge
        check("s1_delay_gap", 32'(k), 32'(ROM_LATENCY + DELAY_CYCLES + 2));
        wait_done("s1_finish", 500);
        check("s1_final_addr", 32'(rom_addr), 32'd3);
        check("s1_busy_low", 32'(busy), 32'd0);
        check("s1_writes", 32'(accept_count - base), 32'd2);
        check("s1_queue_empty", 32'(exp_q.size()), 32'd0);

        // 2: ready held low for 50 cycles
        foreach (rom[i]) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        exp_q.push_back(16'h1280);
        hold_ready_low = 1'b1;
        base = accept_count;
        pulse_start();
        k = 0;
        while (sccb.o_sccb_valid !== 1'b1 && k < 50) begin
            step(1);
            k++;
        end
        check("s2_valid_seen", 32'(sccb.o_sccb_valid), 32'd1);
        stable = 0;
        for (int i = 0; i < 50; i++) begin
            if (sccb.o_sccb_valid === 1'b1 && sccb.o_sccb_reg === 8'h12 && sccb.o_sccb_data === 8'h80)
                stable++;
            step(1);
        end
        check("s2_hold_stable", 32'(stable), 32'd50);
        check("s2_no_accept_while_low", 32'(accept_count - base), 32'd0);
        hold_ready_low = 1'b0;
        wait_done("s2_finish", 300);
        check("s2_writes", 32'(accept_count - base), 32'd1);
        check("s2_final_addr", 32'(rom_addr), 32'd1);
        check("s2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6: reg FF with a non-marker value is an ordinary write
        foreach (rom[i]) rom[i] = 16'hFFFF;
        rom[0] = 16'hFF05;
        exp_q.push_back(16'hFF05);
        base = accept_count;
        pulse_start();
        wait_done("s6_finish", 300);
        check("s6_writes", 32'(accept_count - base), 32'd1);
        check("s6_final_addr", 32'(rom_addr), 32'd1);
        check("s6_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4: start ignored while busy, honoured from DONE
        load_basic_rom();
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1214);
        base = accept_count;
        pulse_start();
        wait_accepts("s4_first_write", base + 1, 200);
        step(3);
        pulse_start();
        check("s4_busy_wait_done", 32'(busy), 32'd1);
        wait_addr("s4_reach_addr1", 8'd1, 200);
        step(6);
        pulse_start();
        check("s4_addr_in_delay", 32'(rom_addr), 32'd1);
        wait_done("s4_finish", 800);
        check("s4_final_addr", 32'(rom_addr), 32'd3);
        check("s4_writes", 32'(accept_count - base), 32'd2);
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1214);
        base = accept_count;
        pulse_start();
        check("s4_restart_addr", 32'(rom_addr), 32'd0);
        check("s4_restart_done_low", 32'(done), 32'd0);
        wait_done("s4_rerun_finish", 800);
        check("s4_rerun_addr", 32'(rom_addr), 32'd3);
        check("s4_rerun_writes", 32'(accept_count - base), 32'd2);
        check("s4_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3: no end marker, the run stops at the last address
        foreach (rom[i]) rom[i] = 16'h1100;
        for (int i = 0; i < 256; i++) exp_q.push_back(16'h1100);
        base = accept_count;
        pulse_start();
        wait_done("s3_finish", 20000);
        check("s3_final_addr", 32'(rom_addr), 32'd255);
        check("s3_writes", 32'(accept_count - base), 32'd256);
        check("s3_queue_empty", 32'(exp_q.size()), 32'd0);
        step(5);
        check("s3_no_wrap", 32'(rom_addr), 32'd255);
        check("s3_busy_low", 32'(busy), 32'd0);

        // 5: reset during WAIT_DONE, late done pulse is ignored
        foreach (rom[i]) rom[i] = 16'hFFFF;
        rom[0] = 16'h1280;
        rom[1] = 16'h1214;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1214);
        base = accept_count;
        pulse_start();
        wait_accepts("s5_first_write", base + 1, 200);
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("s5_rst_addr",  32'(rom_addr), 32'd0);
        check("s5_rst_valid", 32'(sccb.o_sccb_valid), 32'd0);
        check("s5_rst_reg",   32'(sccb.o_sccb_reg), 32'd0);
        check("s5_rst_data",  32'(sccb.o_sccb_data), 32'd0);
        check("s5_rst_busy",  32'(busy), 32'd0);
        check("s5_rst_done",  32'(done), 32'd0);
        exp_q.delete();
        step(40);
        check("s5_no_more_writes", 32'(accept_count - base), 32'd1);
        check("s5_idle_busy", 32'(busy), 32'd0);
        check("s5_idle_addr", 32'(rom_addr), 32'd0);
        check("s5_idle_done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
